// File: rtl/tl_reg_bridge.sv
// TileLink-UL device terminator driving a req/ready register bus.
// Optional ACCESS timeout: define TL_REG_BRIDGE_TIMEOUT_EN.
module tl_reg_bridge #(
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SourceWidth   = 1,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [1:0]             a_size,
  input  logic [SourceWidth-1:0] a_source,
  input  logic [AddrWidth-1:0]   a_address,
  input  logic [3:0]             a_mask,
  input  logic [31:0]            a_data,
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [2:0]             d_opcode,
  output logic [1:0]             d_size,
  output logic [SourceWidth-1:0] d_source,
  output logic                   d_denied,
  output logic [31:0]            d_data,
  output logic                   reg_req,
  output logic                   reg_we,
  output logic [AddrWidth-1:0]   reg_addr,
  output logic [3:0]             reg_be,
  output logic [31:0]            reg_wdata,
  input  logic                   reg_ready,
  input  logic [31:0]            reg_rdata,
  input  logic                   reg_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   get_q;
  logic                   d_valid_q;
  logic [2:0]             d_opcode_q;
  logic [1:0]             d_size_q;
  logic [SourceWidth-1:0] d_source_q;
  logic                   d_denied_q;
  logic [31:0]            d_data_q;
  logic                   reg_req_q;
  logic                   reg_we_q;
  logic [AddrWidth-1:0]   reg_addr_q;
  logic [3:0]             reg_be_q;
  logic [31:0]            reg_wdata_q;

  logic a_fire;
  logic d_fire;
  logic op_ok;
  logic size_ok;
  logic align_ok;
  logic illegal;
  logic is_get;
  logic timeout;

  assign a_ready = (state_q == IDLE);
  assign a_fire  = a_valid && a_ready;
  assign d_fire  = d_valid_q && d_ready;

  // Classify the incoming A request
  always_comb begin
    op_ok    = 1'b0;
    align_ok = 1'b0;
    unique case (a_opcode)
      3'd0, 3'd1, 3'd4: op_ok = 1'b1;
      default:          op_ok = 1'b0;
    endcase
    unique case (a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~a_address[0];
      2'd2:    align_ok = (a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    size_ok = (a_size <= 2'd2);
    illegal = ~(op_ok && size_ok && align_ok);
    is_get  = (a_opcode == 3'd4);
  end

`ifdef TL_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (a_fire) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !reg_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == ACCESS) && !reg_ready
                && (cnt_q == CntLast);

  // Wait counter for the register access
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TimeoutCycles;
  assign timeout        = 1'b0;
`endif

  // Transaction FSM with registered bus outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      get_q       <= 1'b0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 2'd0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= 32'd0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_be_q    <= 4'd0;
      reg_wdata_q <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (a_fire) begin
            get_q       <= is_get;
            d_opcode_q  <= is_get ? 3'd1 : 3'd0;
            d_size_q    <= a_size;
            d_source_q  <= a_source;
            d_data_q    <= 32'd0;
            reg_we_q    <= ~is_get;
            reg_addr_q  <= {a_address[AddrWidth-1:2], 2'b00};
            reg_be_q    <= a_mask;
            reg_wdata_q <= a_data;
            if (illegal) begin
              d_denied_q <= 1'b1;
              d_valid_q  <= 1'b1;
              state_q    <= RESP;
            end else begin
              d_denied_q <= 1'b0;
              reg_req_q  <= 1'b1;
              state_q    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (reg_ready) begin
            reg_req_q  <= 1'b0;
            d_valid_q  <= 1'b1;
            d_denied_q <= reg_error;
            d_data_q   <= (get_q && !reg_error) ? reg_rdata : 32'd0;
            state_q    <= RESP;
          end else if (timeout) begin
            reg_req_q  <= 1'b0;
            d_valid_q  <= 1'b1;
            d_denied_q <= 1'b1;
            d_data_q   <= 32'd0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (d_fire) begin
            d_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          reg_req_q <= 1'b0;
          d_valid_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign d_valid   = d_valid_q;
  assign d_opcode  = d_opcode_q;
  assign d_size    = d_size_q;
  assign d_source  = d_source_q;
  assign d_denied  = d_denied_q;
  assign d_data    = d_data_q;
  assign reg_req   = reg_req_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_be    = reg_be_q;
  assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_tl_reg_bridge.sv
// Directed bench for tl_reg_bridge.
// Timeout scenario follows TL_REG_BRIDGE_TIMEOUT_EN.
module tb_tl_reg_bridge;

  logic        clk_i;
  logic        rst_ni;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [0:0]  a_source;
  logic [11:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [0:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        reg_req;
  logic        reg_we;
  logic [11:0] reg_addr;
  logic [3:0]  reg_be;
  logic [31:0] reg_wdata;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        reg_error;

  int checks;
  int errors;

  tl_reg_bridge #(
    .AddrWidth(12),
    .SourceWidth(1),
    .TimeoutCycles(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied),
    .d_data(d_data),
    .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_be(reg_be),
    .reg_wdata(reg_wdata), .reg_ready(reg_ready),
    .reg_rdata(reg_rdata), .reg_error(reg_error)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one A beat at a negedge; return at the negedge after fire
  task automatic send_a(input logic [2:0] op, input logic [1:0] sz,
                        input logic src, input logic [11:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_valid   = 1'b1;
    check("a_ready_idle", 32'(a_ready), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    a_valid = 1'b0;
  endtask

  // Finish the current response with d_ready high
  task automatic drain;
    d_ready = 1'b1;
    @(negedge clk_i);
    check("drain_dvalid", 32'(d_valid), 32'd0);
  endtask

  logic [11:0] addr_s;
  int          n;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_ni    = 1'b0;
    a_valid   = 1'b0;
    a_opcode  = 3'd0;
    a_size    = 2'd0;
    a_source  = 1'b0;
    a_address = 12'd0;
    a_mask    = 4'd0;
    a_data    = 32'd0;
    d_ready   = 1'b0;
    reg_ready = 1'b0;
    reg_rdata = 32'd0;
    reg_error = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_reg_req", 32'(reg_req), 32'd0);
    check("rst_d_denied", 32'(d_denied), 32'd0);
    check("rst_d_data", d_data, 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // 1: Get 0x004, ready tied high
    reg_ready = 1'b1;
    reg_rdata = 32'hDEADBEEF;
    d_ready   = 1'b0;
    send_a(3'd4, 2'd2, 1'b0, 12'h004, 4'hF, 32'd0);
    check("t1_req", 32'(reg_req), 32'd1);
    check("t1_we", 32'(reg_we), 32'd0);
    check("t1_addr", 32'(reg_addr), 32'h004);
    check("t1_dvalid_early", 32'(d_valid), 32'd0);
    @(negedge clk_i);
    check("t1_req_drop", 32'(reg_req), 32'd0);
    check("t1_dvalid", 32'(d_valid), 32'd1);
    check("t1_opcode", 32'(d_opcode), 32'd1);
    check("t1_data", d_data, 32'hDEADBEEF);
    check("t1_denied", 32'(d_denied), 32'd0);
    check("t1_size", 32'(d_size), 32'd2);
    drain();
    check("t1_a_ready", 32'(a_ready), 32'd1);

    // 2: PutPartial 0x006 size 1
    d_ready = 1'b0;
    send_a(3'd1, 2'd1, 1'b0, 12'h006, 4'hC, 32'hABCD0000);
    check("t2_req", 32'(reg_req), 32'd1);
    check("t2_we", 32'(reg_we), 32'd1);
    check("t2_addr", 32'(reg_addr), 32'h004);
    check("t2_be", 32'(reg_be), 32'hC);
    check("t2_wdata", reg_wdata, 32'hABCD0000);
    @(negedge clk_i);
    check("t2_dvalid", 32'(d_valid), 32'd1);
    check("t2_opcode", 32'(d_opcode), 32'd0);
    check("t2_size", 32'(d_size), 32'd1);
    check("t2_data", d_data, 32'd0);
    drain();

    // 3: Get with reg_ready low for 5 cycles
    d_ready   = 1'b0;
    reg_ready = 1'b0;
    reg_rdata = 32'h12345678;
    send_a(3'd4, 2'd2, 1'b0, 12'h010, 4'hF, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("t3_req", 32'(reg_req), 32'd1);
      check("t3_addr", 32'(reg_addr), 32'h010);
      check("t3_we", 32'(reg_we), 32'd0);
      check("t3_dvalid", 32'(d_valid), 32'd0);
      if (i == 5) reg_ready = 1'b1;
      @(negedge clk_i);
    end
    check("t3_done_dvalid", 32'(d_valid), 32'd1);
    check("t3_done_req", 32'(reg_req), 32'd0);
    check("t3_data", d_data, 32'h12345678);
    drain();

    // 4: d_ready stalled, a second A waiting
    d_ready   = 1'b0;
    reg_rdata = 32'h0000CAFE;
    send_a(3'd4, 2'd2, 1'b1, 12'h020, 4'hF, 32'd0);
    @(negedge clk_i);
    a_opcode  = 3'd0;
    a_size    = 2'd2;
    a_source  = 1'b0;
    a_address = 12'h030;
    a_mask    = 4'hF;
    a_data    = 32'h55AA55AA;
    a_valid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_dvalid", 32'(d_valid), 32'd1);
      check("t4_source", 32'(d_source), 32'd1);
      check("t4_data", d_data, 32'h0000CAFE);
      check("t4_opcode", 32'(d_opcode), 32'd1);
      check("t4_a_ready", 32'(a_ready), 32'd0);
      check("t4_no_req", 32'(reg_req), 32'd0);
      @(negedge clk_i);
    end
    d_ready = 1'b1;
    @(negedge clk_i);
    check("t4_idle", 32'(a_ready), 32'd1);
    check("t4_dvalid_off", 32'(d_valid), 32'd0);
    @(negedge clk_i);
    a_valid = 1'b0;
    check("t4_new_req", 32'(reg_req), 32'd1);
    check("t4_new_addr", 32'(reg_addr), 32'h030);
    check("t4_new_we", 32'(reg_we), 32'd1);
    @(negedge clk_i);
    check("t4_new_src", 32'(d_source), 32'd0);
    drain();

    // 5: illegal requests are denied without reg_req
    d_ready = 1'b0;
    send_a(3'd2, 2'd2, 1'b0, 12'h040, 4'hF, 32'd0);
    check("t5a_req", 32'(reg_req), 32'd0);
    check("t5a_dvalid", 32'(d_valid), 32'd1);
    check("t5a_denied", 32'(d_denied), 32'd1);
    check("t5a_data", d_data, 32'd0);
    drain();
    d_ready = 1'b0;
    send_a(3'd4, 2'd3, 1'b0, 12'h040, 4'hF, 32'd0);
    check("t5b_req", 32'(reg_req), 32'd0);
    check("t5b_denied", 32'(d_denied), 32'd1);
    check("t5b_data", d_data, 32'd0);
    drain();
    d_ready = 1'b0;
    send_a(3'd4, 2'd2, 1'b0, 12'h002, 4'hF, 32'd0);
    check("t5c_req", 32'(reg_req), 32'd0);
    check("t5c_denied", 32'(d_denied), 32'd1);
    check("t5c_data", d_data, 32'd0);
    drain();
    d_ready   = 1'b0;
    reg_error = 1'b1;
    reg_rdata = 32'h11112222;
    send_a(3'd4, 2'd2, 1'b0, 12'h008, 4'hF, 32'd0);
    check("t5d_req", 32'(reg_req), 32'd1);
    @(negedge clk_i);
    check("t5d_denied", 32'(d_denied), 32'd1);
    check("t5d_data", d_data, 32'd0);
    drain();
    reg_error = 1'b0;

    // 6: reg_ready never asserted
    d_ready   = 1'b0;
    reg_ready = 1'b0;
    send_a(3'd4, 2'd2, 1'b0, 12'h00C, 4'hF, 32'd0);
`ifdef TL_REG_BRIDGE_TIMEOUT_EN
    n = 0;
    while (reg_req && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    check("t6_req_cycles", 32'(n), 32'd8);
    check("t6_dvalid", 32'(d_valid), 32'd1);
    check("t6_denied", 32'(d_denied), 32'd1);
    reg_ready = 1'b1;
    reg_rdata = 32'h77777777;
    @(negedge clk_i);
    check("t6_late_data", d_data, 32'd0);
    check("t6_late_denied", 32'(d_denied), 32'd1);
    drain();
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (reg_req) n++;
      @(negedge clk_i);
    end
    check("t6_req_held", 32'(n), 32'd1000);
    check("t6_req_still", 32'(reg_req), 32'd1);
    reg_ready = 1'b1;
    reg_rdata = 32'h00000042;
    @(negedge clk_i);
    check("t6_dvalid", 32'(d_valid), 32'd1);
    check("t6_data", d_data, 32'h00000042);
    drain();
`endif

    // 7: asynchronous reset mid-transaction
    d_ready   = 1'b0;
    reg_ready = 1'b0;
    send_a(3'd0, 2'd2, 1'b1, 12'h044, 4'hF, 32'h1);
    check("t7_req", 32'(reg_req), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t7_req_drop", 32'(reg_req), 32'd0);
    check("t7_dvalid", 32'(d_valid), 32'd0);
    check("t7_a_ready", 32'(a_ready), 32'd1);
    check("t7_addr", 32'(reg_addr), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("t7_post_ready", 32'(a_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
